screen_scanner: RTL and testbench

Reads the parallel RGB screen array produced by the game top level and streams it to the display side as a serial pixel stream, one 24-bit pixel per handshake. Raster order: row 0 first, left to right within each row. Sits between the game board's `screen` output and the display/video driver. Owns frame snapshotting, scan sequencing and frame markers.

---
 rtl/doodle_pkg.sv | 15 +
 rtl/scan_counter.sv | 40 ++++
 rtl/screen_scanner.sv | 137 +++++++++++++
 tb/tb_screen_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared constants and types for the doodle game display path.
// Screen geometry defaults, the rgb pixel layout and the scanner state encoding.
package doodle_pkg;
   localparam int SCR_W      = 30;
   localparam int SCR_H      = 30;
   localparam int PIXEL_BITS = 24;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} scan_state_t;
endpackage

// File: rtl/scan_counter.sv
// Raster position counter for the screen scanner: x runs across a row, then y steps.
// Clear has priority over advance; neither counter ever leaves its legal range.
module scan_counter #(
   parameter int WIDTH  = 30,
   parameter int HEIGHT = 30,
   parameter int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          lastCol,
   output logic          lastPix
);

   assign lastCol = (x == XW'(WIDTH - 1));
   assign lastPix = lastCol && (y == YW'(HEIGHT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (lastCol) begin
            x <= '0;
            // Wrap to row 0 after the final pixel rather than stepping past H-1.
            y <= lastPix ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/screen_scanner.sv
// Streams the parallel screen array out as a raster-ordered pixel stream with frame markers.
// SCREEN_SCANNER_SNAPSHOT_EN: stream from a copy of the screen taken at frame start (tear-free).
module screen_scanner #(
   parameter int SCREEN_WIDTH  = doodle_pkg::SCR_W,
   parameter int SCREEN_HEIGHT = doodle_pkg::SCR_H,
   parameter int PIXEL_BITS    = doodle_pkg::PIXEL_BITS
)(
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [SCREEN_WIDTH*SCREEN_HEIGHT-1:0][PIXEL_BITS-1:0] screen,
   input  logic                                                frame_req,
   output logic [PIXEL_BITS-1:0]                               pix_data,
   output logic                                                pix_valid,
   input  logic                                                pix_ready,
   output logic                                                pix_sof,
   output logic                                                pix_eol,
   output logic                                                pix_eof,
   output logic                                                busy,
   output logic                                                frame_done,
   output logic [15:0]                                         frame_count
);
   import doodle_pkg::*;

   localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int XW   = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
   localparam int YW   = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
   localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

   scan_state_t stateReg;
   logic        pending;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          lastCol;
   logic          lastPix;
   logic          beat;
   logic [XW-1:0] nextX;
   logic [YW-1:0] nextY;
   logic [IW-1:0] nextIdx;
   logic [NPIX-1:0][PIXEL_BITS-1:0] frameSrc;

   assign beat = (stateReg == SEND) && pix_valid && pix_ready;

   scan_counter #(
      .WIDTH  (SCREEN_WIDTH),
      .HEIGHT (SCREEN_HEIGHT),
      .XW     (XW),
      .YW     (YW)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (stateReg == LOAD),
      .advance (beat),
      .x       (x),
      .y       (y),
      .lastCol (lastCol),
      .lastPix (lastPix)
   );

   // Position of the pixel that follows the one currently on pix_data.
   assign nextX   = lastCol ? '0 : x + 1'b1;
   assign nextY   = (lastCol && !lastPix) ? y + 1'b1 : y;
   assign nextIdx = IW'(nextX) * IW'(SCREEN_HEIGHT) + IW'(nextY);

`ifdef SCREEN_SCANNER_SNAPSHOT_EN
   logic [NPIX-1:0][PIXEL_BITS-1:0] snapReg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snapReg <= '0;
      end else if (stateReg == LOAD) begin
         snapReg <= screen;
      end
   end

   assign frameSrc = snapReg;
`else
   assign frameSrc = screen;
`endif

   assign pix_sof = pix_valid && (x == '0) && (y == '0);
   assign pix_eol = pix_valid && lastCol;
   assign pix_eof = pix_valid && lastPix;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg    <= IDLE;
         pending     <= 1'b0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (frame_req || pending) begin
                  stateReg <= LOAD;
                  pending  <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (frame_req) pending <= 1'b1;
               // The snapshot is being written this same cycle, so pixel (0,0) comes from screen.
               pix_data  <= screen[0];
               pix_valid <= 1'b1;
               stateReg  <= SEND;
            end
            SEND: begin
               if (frame_req) pending <= 1'b1;
               if (beat) begin
                  if (lastPix) begin
                     pix_valid   <= 1'b0;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                     stateReg    <= DONE;
                  end else begin
                     pix_data <= frameSrc[nextIdx];
                  end
               end
            end
            DONE: begin
               if (pending || frame_req) begin
                  pending  <= 1'b0;
                  stateReg <= LOAD;
               end else begin
                  busy     <= 1'b0;
                  stateReg <= IDLE;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_screen_scanner.sv
// Scoreboard bench for screen_scanner: stimulus queues expected beats, a negedge monitor pops and compares.
// Honours SCREEN_SCANNER_SNAPSHOT_EN when predicting the live-screen-change frame.
module tb_screen_scanner;
   localparam int W = 30;
   localparam int H = 30;
   localparam int N = W * H;

   typedef struct {
      logic [23:0] d;
      logic        sof;
      logic        eol;
      logic        eof;
   } beat_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [N-1:0][23:0]  screen;
   logic                frame_req;
   logic [23:0]         pix_data;
   logic                pix_valid;
   logic                pix_ready;
   logic                pix_sof;
   logic                pix_eol;
   logic                pix_eof;
   logic                busy;
   logic                frame_done;
   logic [15:0]         frame_count;

   beat_t expQ[$];
   int    checks = 0;
   int    errors = 0;
   int    beatCount = 0;
   int    lastGap = -1;
   int    gapRun = 0;
   bit    prevEof = 0;
   bit    stallPrev = 0;
   bit    prevValid = 0;
   bit    randMode = 0;
   logic [26:0] held;

   screen_scanner #(
      .SCREEN_WIDTH  (W),
      .SCREEN_HEIGHT (H),
      .PIXEL_BITS    (24)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .screen      (screen),
      .frame_req   (frame_req),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_sof     (pix_sof),
      .pix_eol     (pix_eol),
      .pix_eof     (pix_eof),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Beat k is raster position (k%W, k/W); screen holds index x*H+y there.
   task automatic pushFrame(input int splitAt);
      beat_t b;
      for (int k = 0; k < N; k++) begin
         int x = k % W;
         int y = k / W;
         b.d   = (splitAt >= 0 && k >= splitAt) ? 24'hFF0000 : 24'(x * H + y);
         b.sof = (k == 0);
         b.eol = (x == W - 1);
         b.eof = (k == N - 1);
         expQ.push_back(b);
      end
   endtask

   task automatic fillIndex();
      for (int i = 0; i < N; i++) screen[i] = 24'(i);
   endtask

   task automatic pulseReq();
      @(posedge clk); #1 frame_req = 1'b1;
      @(posedge clk); #1 frame_req = 1'b0;
   endtask

   task automatic waitBeats(input int target, input int budget);
      int n = 0;
      while (beatCount < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("beat wait", beatCount >= target, 32'(beatCount), 32'(target));
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while ((expQ.size() != 0 || busy) && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({name, " drain"}, n < budget, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   // Ready driver for the random-backpressure frame.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randMode) pix_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: scoreboard pop on every transfer, stall stability, frame_done timing, inter-frame gap.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (prevEof || frame_done)
            check("frame_done pulse", frame_done === prevEof, 32'(frame_done), 32'(prevEof));
         if (frame_done) $display("frame done, frame_count=%0d", frame_count);
         prevEof = 0;
         if (stallPrev)
            check("stall hold", {pix_valid, pix_data, pix_sof, pix_eol, pix_eof} === {1'b1, held},
                  32'({pix_data, pix_sof, pix_eol, pix_eof}), 32'(held));
         stallPrev = 0;
         if (pix_valid && pix_ready) begin
            if (expQ.size() == 0) begin
               check("unexpected beat", 1'b0, 32'(pix_data), 32'd0);
            end else begin
               e = expQ.pop_front();
               check("beat", {pix_data, pix_sof, pix_eol, pix_eof} === {e.d, e.sof, e.eol, e.eof},
                     32'({pix_data, pix_sof, pix_eol, pix_eof}), 32'({e.d, e.sof, e.eol, e.eof}));
            end
            beatCount++;
            if (pix_eof) prevEof = 1;
         end else if (pix_valid) begin
            stallPrev = 1;
            held = {pix_data, pix_sof, pix_eol, pix_eof};
         end
         if (pix_valid) begin
            if (!prevValid && gapRun > 0) lastGap = gapRun;
            gapRun = 0;
         end else if (busy) begin
            gapRun++;
         end else begin
            gapRun = 0;
         end
         prevValid = pix_valid;
      end
   end

   initial begin
      int base;
      int split;
      reset     = 1'b0;
      frame_req = 1'b0;
      pix_ready = 1'b1;
      fillIndex();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset pix_data", pix_data === 24'd0, 32'(pix_data), 32'd0);
      check("reset markers", {pix_valid, pix_sof, pix_eol, pix_eof} === 4'b0,
            32'({pix_valid, pix_sof, pix_eol, pix_eof}), 32'd0);
      check("reset busy/done", {busy, frame_done} === 2'b0, 32'({busy, frame_done}), 32'd0);
      check("reset frame_count", frame_count === 16'd0, 32'(frame_count), 32'd0);

      // Frame 1: ready held high.
      pushFrame(-1);
      pulseReq();
      check("busy in frame", busy === 1'b1, 32'(busy), 32'd1);
      waitDrain("frame1", 2000);
      check("count after frame1", frame_count === 16'd1, 32'(frame_count), 32'd1);
      check("first-frame lead gap", lastGap == 1, 32'(lastGap), 32'd1);

      // Frame 2: random backpressure.
      pushFrame(-1);
      randMode = 1;
      pulseReq();
      waitDrain("frame2 random ready", 6000);
      randMode = 0;
      #1 pix_ready = 1'b1;
      check("count after frame2", frame_count === 16'd2, 32'(frame_count), 32'd2);

      // Three mid-frame requests merge into a single extra frame.
      pushFrame(-1);
      pushFrame(-1);
      base = beatCount;
      pulseReq();
      waitBeats(base + 100, 2000);
      pulseReq();
      waitBeats(base + 200, 2000);
      pulseReq();
      waitBeats(base + 300, 2000);
      pulseReq();
      waitDrain("pending frames", 4000);
      check("count after pending", frame_count === 16'd4, 32'(frame_count), 32'd4);
      check("inter-frame gap", lastGap == 2, 32'(lastGap), 32'd2);
      repeat (5) @(posedge clk);
      #1;
      check("no third frame", busy === 1'b0 && expQ.size() == 0, 32'(busy), 32'd0);

      // Screen changes after beat 10; live mode picks it up from beat 12.
`ifdef SCREEN_SCANNER_SNAPSHOT_EN
      split = -1;
`else
      split = 12;
`endif
      pushFrame(split);
      base = beatCount;
      pulseReq();
      waitBeats(base + 11, 2000);
      #1;
      for (int i = 0; i < N; i++) screen[i] = 24'hFF0000;
      waitDrain("screen change", 2000);
      check("count after change", frame_count === 16'd5, 32'(frame_count), 32'd5);
      fillIndex();

      // Abort mid-frame with reset.
      pushFrame(-1);
      base = beatCount;
      pulseReq();
      waitBeats(base + 400, 2000);
      #1 reset = 1'b0;
      #1;
      expQ.delete();
      check("abort pix_valid", pix_valid === 1'b0, 32'(pix_valid), 32'd0);
      check("abort busy", busy === 1'b0, 32'(busy), 32'd0);
      check("abort frame_count", frame_count === 16'd0, 32'(frame_count), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort no frame_done", frame_done === 1'b0, 32'(frame_done), 32'd0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      pushFrame(-1);
      pulseReq();
      waitDrain("restart", 2000);
      check("count after restart", frame_count === 16'd1, 32'(frame_count), 32'd1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
